// File: rtl/uart_alu_interface_pkg.sv
// Shared opcode and FSM state definitions for the UART ALU interface, its top-level logic and its bench.
package uart_alu_interface_pkg;

    localparam int unsigned OP_W = 8;

    localparam logic [OP_W-1:0] OP_ADD = 8'h20;
    localparam logic [OP_W-1:0] OP_SUB = 8'h22;
    localparam logic [OP_W-1:0] OP_AND = 8'h24;
    localparam logic [OP_W-1:0] OP_OR  = 8'h25;
    localparam logic [OP_W-1:0] OP_XOR = 8'h26;
    localparam logic [OP_W-1:0] OP_NOR = 8'h27;
    localparam logic [OP_W-1:0] OP_SRA = 8'h03;
    localparam logic [OP_W-1:0] OP_SRL = 8'h02;

    localparam int unsigned STATE_W = 3;

    // Encodings are exported on the debug STATE output and must stay fixed.
    typedef enum logic [STATE_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_CALC = 3'd3,
        S_SEND = 3'd4,
        S_WAIT = 3'd5
    } state_e;

endpackage

// File: rtl/uart_alu_interface_if.sv
// Rx/Tx handshake plus result/debug signals between the UART datapath and the ALU interface.
interface uart_alu_interface_if #(
    parameter int unsigned N_BIT = 8
);
    logic             rx_done;
    logic [N_BIT-1:0] rx_data;
    logic             tx_done;
    logic             tx_start;
    logic [N_BIT-1:0] tx_data;
    logic [N_BIT-1:0] result;
    logic             err;
    logic [2:0]       state;

    modport master (
        output rx_done, rx_data, tx_done,
        input  tx_start, tx_data, result, err, state
    );

    modport slave (
        input  rx_done, rx_data, tx_done,
        output tx_start, tx_data, result, err, state
    );
endinterface

// File: rtl/uart_alu_interface_alu.sv
// Combinational ALU: eight opcodes, modulo-2**N_BIT arithmetic, valid low on an unknown opcode.
module uart_alu_interface_alu
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned N_BIT = 8
) (
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
    input  logic [N_BIT-1:0] op,
    output logic [N_BIT-1:0] y,
    output logic             valid
);
    localparam int unsigned SHW = $clog2(N_BIT);

    logic [SHW-1:0] sh;
    assign sh = b[SHW-1:0];

    always_comb begin
        y     = '0;
        valid = 1'b1;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_SRA:  y = N_BIT'($signed(a) >>> sh);
            OP_SRL:  y = a >> sh;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from Rx, computes the ALU result and hands it to Tx with a start pulse.
// Optional `INTF_TIMEOUT_EN adds an inter-byte timeout that abandons a partial frame.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned N_BIT     = 8,
    parameter int unsigned TO_CYCLES = 1_000_000,
    parameter int unsigned TO_W      = 20
) (
    input logic                clk,
    input logic                rst,
    uart_alu_interface_if.slave bus
);
    state_e           state_q, state_d;
    logic [N_BIT-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
    logic [N_BIT-1:0] result_q, result_d, tx_data_q, tx_data_d;
    logic             err_q, err_d, tx_start_q, tx_start_d;
    logic [N_BIT-1:0] alu_y;
    logic             alu_valid;

    uart_alu_interface_alu #(.N_BIT(N_BIT)) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .y     (alu_y),
        .valid (alu_valid)
    );

`ifdef INTF_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_to;
    assign unused_to = ^{TO_CYCLES, TO_W};
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        tx_data_d = tx_data_q;
        err_d     = err_q;
        case (state_q)
            S_A: if (bus.rx_done) begin
                a_d     = bus.rx_data;
                state_d = S_B;
            end
            S_B: if (bus.rx_done) begin
                b_d     = bus.rx_data;
                state_d = S_OP;
            end
            S_OP: if (bus.rx_done) begin
                op_d    = bus.rx_data;
                state_d = S_CALC;
            end
            S_CALC: begin
                result_d  = alu_y;
                tx_data_d = alu_y;
                err_d     = ~alu_valid;
                state_d   = S_SEND;
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: if (bus.tx_done) state_d = S_A;
            default: state_d = S_A;
        endcase

`ifdef INTF_TIMEOUT_EN
        // Counter only runs while waiting for the 2nd/3rd byte of a frame.
        to_cnt_d = '0;
        if ((state_q == S_B || state_q == S_OP) && !bus.rx_done) begin
            if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
                state_d = S_A;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif

        tx_start_d = (state_d == S_SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
`ifdef INTF_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
`ifdef INTF_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
`endif
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.result   = result_q;
    assign bus.err      = err_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: directed frames, async resets, timeout, then randomized frames vs a reference model.
module tb_uart_alu_interface;
    localparam int unsigned N_BIT     = 8;
    localparam int unsigned TO_CYCLES = 100;
    localparam int unsigned TO_W      = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_alu_interface_if #(.N_BIT(N_BIT)) bus();

    uart_alu_interface #(.N_BIT(N_BIT), .TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  exp_result = 8'h00;
    logic        exp_err    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic; returns {valid, result}.
    function automatic logic [8:0] ref_alu(input int a, input int b, input int op);
        int s;
        int y;
        bit v;
        s = b % 8;
        v = 1'b1;
        case (op)
            'h20: y = (a + b) % 256;
            'h22: y = (a - b + 256) % 256;
            'h24: y = a & b;
            'h25: y = a | b;
            'h26: y = a ^ b;
            'h27: y = 255 - (a | b);
            'h02: y = a / (2 ** s);
            'h03: y = (a >= 128) ? (a / (2 ** s) + 256 - 256 / (2 ** s)) : a / (2 ** s);
            default: begin y = 0; v = 1'b0; end
        endcase
        return {v, 8'(y)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        bus.rx_done = 1'b1;
        bus.rx_data = v;
        step();
        bus.rx_done = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input int gap, input bit extra_rx, input int tx_gap);
        logic [8:0] r;
        repeat (gap) step();
        check("idle_state", 32'(bus.state), 0);
        check("err_sticky", 32'(bus.err), 32'(exp_err));
        send_byte(a);
        check("state_b", 32'(bus.state), 1);
        repeat (gap) step();
        send_byte(b);
        check("state_op", 32'(bus.state), 2);
        repeat (gap) step();
        send_byte(op);
        check("state_calc", 32'(bus.state), 3);
        check("tx_start_early", 32'(bus.tx_start), 0);
        r = ref_alu(int'(a), int'(b), int'(op));
        exp_result = r[7:0];
        exp_err    = ~r[8];
        step();
        check("tx_start_pulse", 32'(bus.tx_start), 1);
        check("state_send", 32'(bus.state), 4);
        check("tx_data", 32'(bus.tx_data), 32'(exp_result));
        check("result", 32'(bus.result), 32'(exp_result));
        check("err", 32'(bus.err), 32'(exp_err));
        step();
        check("tx_start_single", 32'(bus.tx_start), 0);
        check("state_wait", 32'(bus.state), 5);
        if (extra_rx) begin
            send_byte(8'hAA);
            check("wait_ignores_rx", 32'(bus.state), 5);
        end
        repeat (tx_gap) step();
        check("tx_data_held", 32'(bus.tx_data), 32'(exp_result));
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        check("back_to_a", 32'(bus.state), 0);
        check("result_kept", 32'(bus.result), 32'(exp_result));
    endtask

    // Assert reset between clock edges and verify outputs clear without waiting for an edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_state"}, 32'(bus.state), 0);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        step();
        rst = 1'b0;
        exp_result = 8'h00;
        exp_err    = 1'b0;
    endtask

    initial begin
        logic [7:0] ops [8];
        logic [7:0] op;
        ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

        rst         = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(bus.state), 0);
        check("rst_tx_start", 32'(bus.tx_start), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_err", 32'(bus.err), 0);
        rst = 1'b0;
        step();

        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        check("tx_done_ignored", 32'(bus.state), 0);

        run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0, 0);
        check("add_value", 32'(bus.result), 32'h08);
        run_frame(8'h02, 8'h05, 8'h22, 0, 1'b0, 1);
        check("sub_wrap", 32'(bus.result), 32'hFD);
        run_frame(8'h80, 8'h02, 8'h03, 0, 1'b0, 0);
        check("sra_value", 32'(bus.result), 32'hE0);
        run_frame(8'h80, 8'h02, 8'h02, 0, 1'b0, 0);
        check("srl_value", 32'(bus.result), 32'h20);
        run_frame(8'h0F, 8'hF0, 8'h27, 0, 1'b0, 0);
        check("nor_value", 32'(bus.result), 32'h00);
        run_frame(8'h11, 8'h22, 8'h99, 0, 1'b0, 0);
        check("bad_op_err", 32'(bus.err), 1);
        run_frame(8'h01, 8'h01, 8'h20, 0, 1'b1, 2);
        check("err_cleared", 32'(bus.err), 0);
        check("after_extra_rx", 32'(bus.result), 32'h02);

        // Reset while waiting for the opcode byte, then while waiting for TX_DONE.
        send_byte(8'h33);
        send_byte(8'h44);
        check("pre_rst_op", 32'(bus.state), 2);
        async_reset("rst_in_op");
        run_frame(8'h09, 8'h04, 8'h26, 0, 1'b0, 0);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h24);
        step();
        step();
        check("pre_rst_wait", 32'(bus.state), 5);
        async_reset("rst_in_wait");
        run_frame(8'h01, 8'h01, 8'h20, 0, 1'b0, 0);

        // Inter-byte timeout (or indefinite wait without the feature).
        send_byte(8'h07);
        check("to_in_b", 32'(bus.state), 1);
        repeat (TO_CYCLES + 1) step();
`ifdef INTF_TIMEOUT_EN
        check("timeout_to_a", 32'(bus.state), 0);
        check("timeout_err_kept", 32'(bus.err), 32'(exp_err));
`else
        check("no_timeout_b", 32'(bus.state), 1);
        async_reset("rst_after_idle");
`endif
        run_frame(8'h01, 8'h02, 8'h20, 0, 1'b0, 0);
        check("post_idle_add", 32'(bus.result), 32'h03);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 7)];
            else op = 8'($urandom);
            run_frame(8'($urandom), 8'($urandom), op, int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
